rotate_right_seq: RTL and testbench

//  Multi-cycle rotate-right unit: the inverse-direction companion to the ALU's combinational

---
 rtl/rotate_right_seq.sv | 94 +++++++++
 tb/tb_rotate_right_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/rotate_right_seq.sv
// rotate_right_seq: multi-cycle rotate-right, one bit per clock, valid/ready on both sides
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid_i   operands valid; accepted when in_valid_i & in_ready_o
//   in_ready_o   high only in IDLE
//   a_i          operand to rotate
//   b_i          rotate amount; only b_i[SHW-1:0] is used
//   out_valid_o  result valid; high only in DONE
//   out_ready_i  consumer takes result when out_valid_o & out_ready_i
//   result_o     rotated value, registered, changes only on entry to DONE
//   busy_o       high in SHIFT or DONE
module rotate_right_seq #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] result_q;
    logic [SHW-1:0]   cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [SHW-1:0]   n_d;
    logic [WIDTH-1:0] rot_d;
    logic             unused_b;
    // upper amount bits are don't-care: n wraps modulo WIDTH
    assign n_d      = b_i[SHW-1:0];
    assign unused_b = ^b_i[WIDTH-1:SHW];
    assign rot_d    = {sreg_q[0], sreg_q[WIDTH-1:1]};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        sreg_q     <= a_i;
                        cnt_q      <= n_d;
                        in_ready_q <= 1'b0;
                        if (n_d == '0) begin
                            state_q     <= DONE;
                            result_q    <= a_i;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    sreg_q <= rot_d;
                    cnt_q  <= cnt_q - 1'b1;
                    // last step: publish the shifted value directly, not sreg_q
                    if (cnt_q == SHW'(1)) begin
                        state_q     <= DONE;
                        result_q    <= rot_d;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end
    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign busy_o      = ~in_ready_q;
endmodule

// File: tb/tb_rotate_right_seq.sv
// tb_rotate_right_seq: directed and randomized checks of rotate_right_seq against a rotate model
module tb_rotate_right_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        busy;
    int          checks = 0;
    int          errors = 0;
    rotate_right_seq #(.WIDTH(16), .SHW(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .a_i(a),
        .b_i(b),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .result_o(result),
        .busy_o(busy)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [15:0] ror(input logic [15:0] v, input int amt);
        logic [31:0] t;
        t = {v, v} >> (amt % 16);
        return t[15:0];
    endfunction
    task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input int stall, input bit hold);
        int n;
        int lat;
        int w;
        logic [15:0] exp;
        n = int'(bv) % 16;
        exp = ror(av, n);
        out_ready = hold;
        w = 0;
        while (!in_ready && w < 50) begin
            tick();
            w++;
        end
        chk("ready_wait", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = av;
        b = bv;
        tick();
        lat = 0;
        chk("busy_after_accept", 32'(busy), 32'd1);
        while (!out_valid && lat < 40) begin
            chk("in_ready_shift", 32'(in_ready), 32'd0);
            in_valid = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(lat), 32'(n));
        chk("result", 32'(result), 32'(exp));
        chk("in_ready_done", 32'(in_ready), 32'd0);
        if (!hold) begin
            for (int i = 0; i < stall; i++) begin
                in_valid = 1'($urandom);
                a = 16'($urandom);
                b = 16'($urandom);
                tick();
                chk("bp_valid", 32'(out_valid), 32'd1);
                chk("bp_result", 32'(result), 32'(exp));
                chk("bp_in_ready", 32'(in_ready), 32'd0);
            end
        end
        out_ready = 1'b1;
        in_valid = 1'($urandom);
        tick();
        in_valid = 1'b0;
        out_ready = hold;
        chk("exit_valid", 32'(out_valid), 32'd0);
        chk("exit_busy", 32'(busy), 32'd0);
        chk("hold_result", 32'(result), 32'(exp));
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        tick();
        run_op(16'h0001, 16'd5, 0, 1'b1);
        chk("t1", 32'(result), 32'h0800);
        run_op(16'h0001, 16'd8, 0, 1'b1);
        chk("t2", 32'(result), 32'h0100);
        run_op(16'hBEEF, 16'd0, 1, 1'b0);
        run_op(16'hBEEF, 16'd16, 0, 1'b0);
        run_op(16'h000F, 16'h0013, 2, 1'b0);
        chk("t4", 32'(result), 32'hE001);
        run_op(16'hA5C3, 16'd9, 10, 1'b0);
        in_valid = 1'b1;
        a = 16'h1234;
        b = 16'd7;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_idle", 32'(out_valid), 32'd0);
        end
        run_op(16'h1234, 16'd4, 0, 1'b0);
        chk("t6", 32'(result), 32'h4123);
        for (int i = 0; i < 40; i++) begin
            run_op(16'($urandom), 16'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
